seg7_scan: RTL and testbench
============================

# seg7_scan

Time-multiplexed seven-segment display driver for the board's hex readout of CPU state (PC, register or memory word). It sits directly downstream of the 1 kHz clock divider. It takes that divider's square-wave output as a scan rate, runs it through a synchronizer and edge detector, and steps one digit per scan edge. A frame-coherent snapshot of the displayed value prevents tearing. Anode, segment and decimal-point outputs are registered, with anti-ghosting blanking between digits.

## Interface
- DIGITS, 8: number of multiplexed digits; value width is 4*DIGITS.
- ACTIVE_LOW, 1: 1 means an/seg/dp are driven low-true (board default); 0 means high-true.
- GHOST, 4: CLK cycles all anodes are held off after each digit change; 0 disables blanking.

- CLK  in  1  system clock; only clock in the block.
- RST  in  1  reset, asynchronous, active-high.
- scan_clk  in  1  divided scan-rate level from the 1 kHz divider; treated as data sampled in CLK domain.
- value  in  4*DIGITS  hex value to display; nibble i drives digit i (digit 0 rightmost).
- dp_mask  in  DIGITS  decimal point enable per digit.
- blank_zero  in  1  1 = suppress leading zero digits.
- an  out  DIGITS  digit anode enables, one-hot (in active sense) or all off.
- seg  out  7  segments {g,f,e,d,c,b,a}.
- dp  out  1  decimal point.

## Operation
- Synchronizer: two flops s1, s2 sample scan_clk, followed by history flop s3. tick = s2 & ~s3; one CLK wide per scan_clk rising edge.
- Digit index idx, width clog2(DIGITS):
  - On tick, idx <= idx+1.
  - Wraps DIGITS-1 -> 0.
- Snapshot registers snap_val, snap_dp, snap_bz:
  - Load value, dp_mask and blank_zero on the same edge that idx wraps to 0.
  - Otherwise hold; all digits of one frame come from one snapshot.
- Leading-zero blanking, evaluated on the snapshot:
  - When snap_bz=1, digit i≥1 is blank if nibbles i..DIGITS-1 are all zero.
  - Digit 0 is never blanked.
  - A blank digit keeps its anode off for its whole slot. dp still follows snap_dp[i] but is invisible with anode off.
- Decode: standard hex 0-F font (0=0111111, 1=0000110, A=1110111, D=1011110 active-high {g..a}).
  - ACTIVE_LOW inverts seg, dp and an.
- Ghost counter:
  - Loaded with GHOST on tick and decrements to 0.
  - While nonzero, an is all off.
  - A tick while the counter is nonzero reloads it to GHOST.
- Output registers, updated on the edge after tick:
  - seg <= font(snap_val nibble idx_new).
  - dp <= snap_dp[idx_new].
  - an <= select(idx_new) when GHOST=0 and the digit is not blank; otherwise all off.
  - When the ghost count reaches 0, an <= select(idx), unless the digit is blank.
- Reset (async, immediate, no clock needed):
  - s1=s2=s3=0, idx=0, snap_val=0, snap_dp=0, snap_bz=0, ghost=0.
  - an all off, seg all off, dp off. With ACTIVE_LOW=1: an=all 1s, seg=7'h7F, dp=1.
- After reset release, outputs stay off until the first tick.
- If scan_clk is already high at release, its first sample counts as a rising edge.

## Timing
- Let edge E1 be the first CLK edge sampling scan_clk=1.
  - s1=1 at E1; s2=1 at E2, so tick is high during cycle E2-E3.
  - idx, seg and dp update at E3.
  - an is all off from E3 through E3+GHOST-1.
  - an selects the new digit at E3+GHOST.
- Snapshot coherency: a value change is first visible in digit 0, at the tick after the current frame completes. Worst-case latency is DIGITS scan periods plus 3 CLK.
- scan_clk must hold high and low for at least 2 CLK each. GHOST must be less than the scan period in CLK cycles, otherwise an never re-enables; this is the integrator's responsibility.
- Simultaneous tick and wrap: snapshot load and idx=0 occur on the same edge, and digit 0 decodes from the new snapshot at that edge.

## Test plan
- Reset: assert RST with no CLK edges -> an=8'hFF, seg=7'h7F, dp=1 immediately. Release, hold scan_clk=0 for 100 cycles -> outputs unchanged.
- Decode: value=32'h1234ABCD, blank_zero=0, dp_mask=0, run 2 frames. In the second frame:
  - digit 0 slot gives an=8'hFE, seg=7'h21 (D).
  - digit 7 slot gives an=8'h7F, seg=7'h79 (1).
  - dp=1 throughout.
- Leading zeros: value=32'h000000A0, blank_zero=1, after one frame:
  - digit 0: seg=7'h40 (0), an=8'hFE.
  - digit 1: seg=7'h08 (A), an=8'hFD.
  - digits 2-7: an=8'hFF for the entire slot.
- Cycle timing, GHOST=4: raise scan_clk at E1 ->
  - idx and seg change at E3.
  - an=8'hFF over E3..E6.
  - an=~(1<<idx) at E7.
  - Exactly one idx step per scan_clk rise; none on the fall.
- Snapshot: change value from 32'h11111111 to 32'h22222222 while idx=3 -> digits 4-7 still show 1 in this frame; digit 0 of the next frame shows 2.
- Reset mid-scan: assert RST asynchronously at idx=5, between clock edges -> outputs go off without a CLK edge. After release and the first tick, idx=1 and the snapshot is zero, so seg=7'h40 and digit 1 is displayed.

Source files
------------

// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed seven-segment display driver.
//
// Steps one digit per rising edge of a slow scan-rate level (scan_clk), which
// is synchronized into the CLK domain. Each frame displays a coherent snapshot
// of value/dp_mask/blank_zero taken when the digit index wraps to 0. Anodes
// are held off for GHOST cycles after each digit change to avoid ghosting.
//
// Ports:
//   CLK        system clock
//   RST        asynchronous active-high reset
//   scan_clk   scan-rate level, sampled as data in the CLK domain
//   value      4*DIGITS hex value; nibble i drives digit i (digit 0 rightmost)
//   dp_mask    per-digit decimal point enable
//   blank_zero 1 = suppress leading zero digits
//   an         digit anode enables, one-hot in active sense or all off
//   seg        segments {g,f,e,d,c,b,a}
//   dp         decimal point
module seg7_scan #(
    parameter int DIGITS     = 8,
    parameter bit ACTIVE_LOW = 1'b1,
    parameter int GHOST      = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  scan_clk,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic                  blank_zero,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int GW = (GHOST > 0) ? $clog2(GHOST + 1) : 1;

    localparam logic [IW-1:0]     LAST    = IW'(DIGITS - 1);
    localparam logic [GW-1:0]     GLOAD   = GW'(GHOST);
    // "Off" levels in the output's active sense; XOR with these converts
    // an active-high pattern into the driven polarity.
    localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{ACTIVE_LOW}};
    localparam logic [6:0]        SEG_OFF = {7{ACTIVE_LOW}};

    logic                s1, s2, s3;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] snap_val;
    logic [DIGITS-1:0]   snap_dp;
    logic                snap_bz;
    logic [GW-1:0]       ghost;

    logic                tick;
    logic                wrap;
    logic [IW-1:0]       idx_new;
    logic [4*DIGITS-1:0] src_val;
    logic [DIGITS-1:0]   src_dp;
    logic                src_bz;
    logic [3:0]          nib;
    logic                new_blank;
    logic                cur_blank;

    // Active-high hex font, {g,f,e,d,c,b,a}.
    function automatic logic [6:0] font(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    // Digit d is blank when suppression is on, d is not the rightmost digit,
    // and every nibble from d upward is zero.
    function automatic logic is_blank(input logic [4*DIGITS-1:0] v,
                                      input logic                bz,
                                      input logic [IW-1:0]       d);
        logic upper_nz;
        upper_nz = 1'b0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (k >= 32'(d) && v[4*k +: 4] != 4'h0) upper_nz = 1'b1;
        end
        return bz && (d != '0) && !upper_nz;
    endfunction

    function automatic logic [DIGITS-1:0] sel(input logic [IW-1:0] d);
        return DIGITS'(1) << d;
    endfunction

    always_comb begin
        tick    = s2 & ~s3;
        wrap    = tick && (idx == LAST);
        idx_new = (idx == LAST) ? '0 : idx + IW'(1);
        // On a wrap the snapshot loads on this same edge, so digit 0 must
        // already decode from the incoming inputs rather than the old snapshot.
        src_val = wrap ? value      : snap_val;
        src_dp  = wrap ? dp_mask    : snap_dp;
        src_bz  = wrap ? blank_zero : snap_bz;
        nib       = src_val[4*int'(idx_new) +: 4];
        new_blank = is_blank(src_val, src_bz, idx_new);
        cur_blank = is_blank(snap_val, snap_bz, idx);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
            idx      <= '0;
            snap_val <= '0;
            snap_dp  <= '0;
            snap_bz  <= 1'b0;
            ghost    <= '0;
            an       <= AN_OFF;
            seg      <= SEG_OFF;
            dp       <= ACTIVE_LOW;
        end else begin
            s1 <= scan_clk;
            s2 <= s1;
            s3 <= s2;
            if (tick) begin
                idx <= idx_new;
                if (wrap) begin
                    snap_val <= value;
                    snap_dp  <= dp_mask;
                    snap_bz  <= blank_zero;
                end
                seg   <= font(nib) ^ SEG_OFF;
                dp    <= src_dp[idx_new] ^ ACTIVE_LOW;
                ghost <= GLOAD;
                if (GHOST == 0 && !new_blank) an <= AN_OFF ^ sel(idx_new);
                else                          an <= AN_OFF;
            end else if (ghost != '0) begin
                ghost <= ghost - GW'(1);
                if (ghost == GW'(1)) an <= cur_blank ? AN_OFF : (AN_OFF ^ sel(idx));
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan (DIGITS=8, ACTIVE_LOW=1, GHOST=4).
// A behavioural model tracks scan rises, digit steps, frame snapshots and
// blanking time; every negedge the DUT outputs are compared against it.
module tb_seg7_scan;

    localparam int DIGITS = 8;
    localparam int GHOST  = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        scan_clk = 1'b0;
    logic [31:0] value = '0;
    logic [7:0]  dp_mask = '0;
    logic        blank_zero = 1'b0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    seg7_scan #(.DIGITS(DIGITS), .ACTIVE_LOW(1'b1), .GHOST(GHOST)) dut (
        .CLK(CLK), .RST(RST), .scan_clk(scan_clk), .value(value),
        .dp_mask(dp_mask), .blank_zero(blank_zero),
        .an(an), .seg(seg), .dp(dp)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    logic [6:0] font_hi [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model state
    int          m_edge  = 0;
    int          m_steps = 0;
    int          m_since = 0;
    int          pend[$];
    logic        m_last  = 1'b0;
    logic [31:0] m_val   = '0;
    logic [7:0]  m_dp    = '0;
    logic        m_bz    = 1'b0;
    logic [7:0]  e_an    = 8'hFF;
    logic [6:0]  e_seg   = 7'h7F;
    logic        e_dp    = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_outputs();
        int c;
        logic blank;
        if (m_steps == 0) begin
            e_an  = 8'hFF;
            e_seg = 7'h7F;
            e_dp  = 1'b1;
        end else begin
            c     = m_steps % DIGITS;
            e_seg = ~font_hi[(m_val >> (4*c)) & 32'hF];
            e_dp  = ~m_dp[c];
            blank = m_bz && (c >= 1) && ((m_val >> (4*c)) == 0);
            e_an  = (m_since >= GHOST && !blank) ? ~(8'(1) << c) : 8'hFF;
        end
    endtask

    // Model: a scan rise seen at edge n produces a digit step at edge n+2.
    initial forever begin
        @(posedge CLK or posedge RST);
        if (RST) begin
            m_edge = 0; m_steps = 0; m_since = 0; pend.delete();
            m_last = 1'b0; m_val = '0; m_dp = '0; m_bz = 1'b0;
        end else begin
            m_edge++;
            if (m_since < 1000) m_since++;
            if (pend.size() > 0 && pend[0] == m_edge) begin
                void'(pend.pop_front());
                m_steps++;
                m_since = 0;
                if (m_steps % DIGITS == 0) begin
                    m_val = value; m_dp = dp_mask; m_bz = blank_zero;
                end
            end
            if (scan_clk && !m_last) pend.push_back(m_edge + 2);
            m_last = scan_clk;
        end
        model_outputs();
    end

    initial forever begin
        @(negedge CLK);
        chk("an", 32'(an), 32'(e_an));
        chk("seg", 32'(seg), 32'(e_seg));
        chk("dp", 32'(dp), 32'(e_dp));
    end

    task automatic period(input int hi, input int lo);
        @(negedge CLK);
        scan_clk = 1'b1;
        repeat (hi) @(negedge CLK);
        scan_clk = 1'b0;
        repeat (lo - 1) @(negedge CLK);
    endtask

    task automatic run_to(input int d);
        int n = 0;
        do begin
            period(6, 6);
            n++;
        end while (!(m_steps > 0 && m_steps % DIGITS == d) && n < 2*DIGITS + 2);
        if (!(m_steps > 0 && m_steps % DIGITS == d)) begin
            checks++;
            errors++;
            $display("FAIL run_to: digit %0d not reached, model step count %0d", d, m_steps);
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        // Asynchronous reset with no clock edge yet
        RST = 1'b1;
        #2;
        chk("rst_an", 32'(an), 32'h0FF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'h1);
        @(negedge CLK);
        RST = 1'b0;
        repeat (100) @(negedge CLK);
        chk("idle_an", 32'(an), 32'h0FF);
        chk("idle_seg", 32'(seg), 32'h7F);

        // Edge-accurate timing of the first step (idx 0 -> 1, zero snapshot)
        scan_clk = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            @(negedge CLK);
            if (e <= 2) begin
                chk("t_pre_seg", 32'(seg), 32'h7F);
                chk("t_pre_an", 32'(an), 32'h0FF);
            end else if (e <= 6) begin
                chk("t_ghost_seg", 32'(seg), 32'h40);
                chk("t_ghost_an", 32'(an), 32'h0FF);
            end else begin
                chk("t_on_seg", 32'(seg), 32'h40);
                chk("t_on_an", 32'(an), 32'h0FD);
            end
        end
        repeat (3) @(negedge CLK);
        scan_clk = 1'b0;
        repeat (8) @(negedge CLK);
        chk("fall_an", 32'(an), 32'h0FD);
        chk("fall_steps", 32'(m_steps), 32'd1);

        // Decode
        value = 32'h1234ABCD; dp_mask = '0; blank_zero = 1'b0;
        run_to(0);
        chk("dec0_an", 32'(an), 32'h0FE);
        chk("dec0_seg", 32'(seg), 32'h21);
        chk("dec0_dp", 32'(dp), 32'h1);
        chk("dec0_model_seg", 32'(e_seg), 32'h21);
        run_to(7);
        chk("dec7_an", 32'(an), 32'h07F);
        chk("dec7_seg", 32'(seg), 32'h79);
        chk("dec7_model_an", 32'(e_an), 32'h07F);

        // Leading-zero blanking
        value = 32'h000000A0; blank_zero = 1'b1;
        run_to(0);
        chk("lz0_seg", 32'(seg), 32'h40);
        chk("lz0_an", 32'(an), 32'h0FE);
        period(6, 6);
        chk("lz1_seg", 32'(seg), 32'h08);
        chk("lz1_an", 32'(an), 32'h0FD);
        for (int d = 2; d < DIGITS; d++) begin
            period(6, 6);
            chk("lz_blank_an", 32'(an), 32'h0FF);
        end
        chk("lz_model_an", 32'(e_an), 32'h0FF);

        // Snapshot coherency
        value = 32'h11111111; blank_zero = 1'b0;
        run_to(0);
        run_to(3);
        value = 32'h22222222;
        period(6, 6);
        chk("snap4_seg", 32'(seg), 32'h79);
        chk("snap4_an", 32'(an), 32'h0EF);
        run_to(7);
        chk("snap7_seg", 32'(seg), 32'h79);
        run_to(0);
        chk("snap0_seg", 32'(seg), 32'h24);
        chk("snap0_an", 32'(an), 32'h0FE);

        // Randomized inputs and scan timing
        for (int i = 0; i < 60; i++) begin
            int unsigned sh;
            value = $urandom;
            sh = $urandom_range(0, 8);
            value = (sh == 8) ? 32'h0 : (value >> (4*sh));
            dp_mask = 8'($urandom);
            blank_zero = 1'($urandom);
            period(int'($urandom_range(3, 10)), int'($urandom_range(3, 10)));
        end

        // Reset mid-scan, between clock edges
        value = 32'h87654321; blank_zero = 1'b0;
        run_to(5);
        @(negedge CLK);
        #2;
        RST = 1'b1;
        #1;
        chk("mrst_an", 32'(an), 32'h0FF);
        chk("mrst_seg", 32'(seg), 32'h7F);
        chk("mrst_dp", 32'(dp), 32'h1);
        @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        period(6, 6);
        chk("mrst_after_seg", 32'(seg), 32'h40);
        chk("mrst_after_an", 32'(an), 32'h0FD);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
